counter_seq_ctrl: RTL and testbench

Sequencing controller for the team's 12-bit loadable up-counter (ports `reset`, `load`, `eneable`, `b`, `c`). It accepts a count job (start value, end value) over a valid/ready handshake, drives the counter's load, enable and clear lines, watches the counter's output, and pulses `done` when the end value is reached. It sits between a job source (FSM or register block) and one counter instance; the counter stays a separate module.

---
 rtl/counter_seq_ctrl.sv | 109 ++++++++++
 tb/tb_counter_seq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a 12-bit loadable up-counter: load start, count to end, pulse done.
// Optional auto-repeat mode is enabled by defining COUNTER_SEQ_REPEAT_EN (adds input rpt).
module counter_seq_ctrl #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_b,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
`ifdef COUNTER_SEQ_REPEAT_EN
    input  logic             rpt,
`endif
    output logic [WIDTH-1:0] steps
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] end_q;
    logic [WIDTH-1:0] steps_q;
    logic             clr_q;
    logic             match;
    logic             run_go;
    logic             rpt_hit;

    assign match  = (cnt_in == end_q);
    assign run_go = (state == RUN) && !abort && !pause;

`ifdef COUNTER_SEQ_REPEAT_EN
    assign rpt_hit = run_go && match && rpt;
`else
    assign rpt_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= '0;
            end_q   <= '0;
            steps_q <= '0;
            clr_q   <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            // Abort wins over everything except reset, but only once a job is active
            if (abort && state != IDLE) begin
                state <= IDLE;
                clr_q <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            start_q <= start_val;
                            end_q   <= end_val;
                            steps_q <= '0;
                            state   <= LOAD;
                        end
                    end
                    LOAD: state <= RUN;
                    RUN: begin
                        if (!pause) begin
                            if (match) begin
                                if (rpt_hit) begin
                                    steps_q <= '0;
                                    state   <= LOAD;
                                end else begin
                                    state <= DONE;
                                end
                            end else begin
                                steps_q <= steps_q + ONE;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ready    = (state == IDLE);
    assign busy     = (state != IDLE);
    assign cnt_load = (state == LOAD);
    assign cnt_clr  = clr_q;
    assign cnt_b    = start_q;
    assign steps    = steps_q;
    assign cnt_en   = run_go && !match;
    // An abort landing on the DONE cycle suppresses the completion pulse
    assign done     = ((state == DONE) && !abort) || rpt_hit;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl with a behavioural 12-bit counter attached.
module tb_counter_seq_ctrl;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         pause;
    logic         abort;
    logic [W-1:0] start_val;
    logic [W-1:0] end_val;
    logic [W-1:0] cnt_in;
    logic [W-1:0] cnt_b;
    logic [W-1:0] steps;
    logic         ready, cnt_load, cnt_en, cnt_clr, busy, done;

    typedef struct {
        logic [W-1:0] steps;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc        = 0;
    int   passCount  = 0;
    int   checkCount = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ready    (ready),
        .start_val(start_val),
        .end_val  (end_val),
        .pause    (pause),
        .abort    (abort),
        .cnt_in   (cnt_in),
        .cnt_load (cnt_load),
        .cnt_b    (cnt_b),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .busy     (busy),
        .done     (done),
        .steps    (steps)
    );

    // Loadable up-counter the controller drives
    always @(posedge clk) begin
        if (reset || cnt_clr)
            cnt_in <= '0;
        else if (cnt_load)
            cnt_in <= cnt_b;
        else if (cnt_en)
            cnt_in <= cnt_in + 12'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Completion monitor: every done pulse must match the oldest queued job
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected done", {31'd0, done}, 32'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("done cycle", cyc, e.cyc);
                checkOutput("done steps", {20'd0, steps}, {20'd0, e.steps});
            end
        end
    end

    // Entered and left at posedge+#1; pause is held in cycles pstart..pstart+plen-1
    task automatic applyStimulus(input logic [W-1:0] s, input logic [W-1:0] e,
                                 input int pstart, input int plen,
                                 input logic [W-1:0] expN, input int expDone);
        int   e0;
        int   enCount;
        int   guard;
        exp_t x;
        enCount = 0;
        guard   = 0;
        while (ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (ready !== 1'b1) checkOutput("ready timeout", {31'd0, ready}, 32'd1);
        start     = 1'b1;
        start_val = s;
        end_val   = e;
        @(posedge clk); #1;
        start = 1'b0;
        e0    = cyc;
        x.steps = expN;
        x.cyc   = e0 + expDone - 1;
        sbq.push_back(x);
        for (int k = 1; k <= expDone + 1; k++) begin
            pause = (k >= pstart && k < pstart + plen);
            @(negedge clk);
            if (k == 1) begin
                checkOutput("load pulse", {31'd0, cnt_load}, 32'd1);
                checkOutput("load cnt_b", {20'd0, cnt_b}, {20'd0, s});
                checkOutput("busy in load", {31'd0, busy}, 32'd1);
                checkOutput("clr idle", {31'd0, cnt_clr}, 32'd0);
            end
            if (cnt_en === 1'b1) enCount++;
            if (cnt_en === 1'b1 && cnt_load === 1'b1)
                checkOutput("load/en overlap", {31'd0, cnt_load}, 32'd0);
            if (k == expDone + 1) begin
                checkOutput("ready back", {31'd0, ready}, 32'd1);
                checkOutput("en count", enCount, {20'd0, expN});
            end
            @(posedge clk); #1;
        end
        pause = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " ready"}, {31'd0, ready}, 32'd1);
        checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " cnt_load"}, {31'd0, cnt_load}, 32'd0);
        checkOutput({tag, " cnt_en"}, {31'd0, cnt_en}, 32'd0);
        checkOutput({tag, " cnt_clr"}, {31'd0, cnt_clr}, 32'd0);
        checkOutput({tag, " steps"}, {20'd0, steps}, 32'd0);
        checkOutput({tag, " cnt_b"}, {20'd0, cnt_b}, 32'd0);
    endtask

    initial begin
        logic found;
        int   guard;
        reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
        start_val = '0; end_val = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checkIdleOutputs("reset");

        applyStimulus(12'h005, 12'h008, 0, 0, 12'd3, 6);
        applyStimulus(12'hFFE, 12'h001, 0, 0, 12'd3, 6);
        applyStimulus(12'h100, 12'h100, 0, 0, 12'd0, 3);
        applyStimulus(12'h000, 12'h004, 3, 2, 12'd4, 9);

        // Abort while the counter shows 0x002
        start = 1'b1; start_val = 12'h000; end_val = 12'h010;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int g = 0; g < 50 && !found; g++) begin
            @(negedge clk);
            if (cnt_in == 12'h002 && cnt_en === 1'b1) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!found) checkOutput("abort wait", {20'd0, cnt_in}, 32'h2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort clr", {31'd0, cnt_clr}, 32'd1);
        checkOutput("abort ready", {31'd0, ready}, 32'd1);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort steps", {20'd0, steps}, 32'd2);
        applyStimulus(12'h003, 12'h005, 0, 0, 12'd2, 5);

        // Reset in the middle of a long run
        start = 1'b1; start_val = 12'h000; end_val = 12'h020;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        checkOutput("midrun busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkIdleOutputs("midrun reset");

        applyStimulus(12'h7FF, 12'h801, 0, 0, 12'd2, 5);

        guard = 0;
        while (sbq.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("scoreboard drained", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
